// File: rtl/quad_lane_serializer_pkg.sv
// Shared types for the quad lane serializer: FSM states, lane count and lane index.
package quad_lane_serializer_pkg;
    localparam int LANE_CNT = 4;

    typedef logic [1:0] lane_idx_t;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;
endpackage

// File: rtl/quad_lane_serializer_lane_mask_scan.sv
// Combinational scan: lowest set mask bit at or above start, plus whether it is the highest set bit.
// Zero latency; no handshake of its own.
module lane_mask_scan
    import quad_lane_serializer_pkg::*;
(
    input  logic [LANE_CNT-1:0] mask,
    input  logic [2:0]          start,
    output lane_idx_t           nxt_idx,
    output logic                is_last
);

    always_comb begin
        nxt_idx = '0;
        is_last = 1'b1;
        // Descending walk so the lowest qualifying index wins.
        for (int i = LANE_CNT - 1; i >= 0; i--) begin
            if (mask[i] && (i >= int'(start))) begin
                nxt_idx = lane_idx_t'(i);
            end
        end
        for (int i = 0; i < LANE_CNT; i++) begin
            if (mask[i] && (i > int'(nxt_idx))) begin
                is_last = 1'b0;
            end
        end
    end

endmodule

// File: rtl/quad_lane_serializer.sv
// Captures four lane words in one handshake and streams the enabled lanes out in order a..d.
// First word 1 cycle after accept, back-to-back bundles without gaps; out stall freezes output and blocks new bundles.
module quad_lane_serializer
    import quad_lane_serializer_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic [WIDTH-1:0] in_c,
    input  logic [WIDTH-1:0] in_d,
    input  logic [3:0]       in_mask,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [1:0]       out_lane,
    output logic             out_last,
    output logic             drop_pulse,
    output logic [CNT_W-1:0] sent_count
);

    state_t              state_q, state_d;
    lane_idx_t           lane_q, lane_d;
    logic                last_q, last_d;
    logic [LANE_CNT-1:0] mask_q, mask_d;
    logic [WIDTH-1:0]    word_q [LANE_CNT];
    logic [WIDTH-1:0]    word_d [LANE_CNT];
    logic                drop_q, drop_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;

    lane_idx_t first_idx, adv_idx;
    logic      first_last, adv_last;
    logic      accept, out_hs;

    lane_mask_scan u_first_scan (
        .mask    (in_mask),
        .start   (3'd0),
        .nxt_idx (first_idx),
        .is_last (first_last)
    );

    lane_mask_scan u_adv_scan (
        .mask    (mask_q),
        .start   ({1'b0, lane_q} + 3'd1),
        .nxt_idx (adv_idx),
        .is_last (adv_last)
    );

    assign out_valid  = (state_q == SEND);
    assign out_data   = out_valid ? word_q[lane_q] : '0;
    assign out_lane   = lane_q;
    assign out_last   = out_valid && last_q;
    assign drop_pulse = drop_q;
    assign sent_count = cnt_q;

    // Finishing the last word frees the capture registers in the same cycle.
    assign in_ready = (state_q == IDLE) || (out_valid && out_ready && last_q);
    assign accept   = in_valid && in_ready;
    assign out_hs   = out_valid && out_ready;

    always_comb begin
        state_d = state_q;
        lane_d  = lane_q;
        last_d  = last_q;
        mask_d  = mask_q;
        word_d  = word_q;
        drop_d  = 1'b0;
        cnt_d   = cnt_q;

        if (out_hs) begin
            if (cnt_q != {CNT_W{1'b1}}) begin
                cnt_d = cnt_q + 1'b1;
            end
            if (last_q) begin
                state_d = IDLE;
            end else begin
                lane_d = adv_idx;
                last_d = adv_last;
            end
        end

        if (accept) begin
            if (in_mask != 4'b0000) begin
                word_d[0] = in_a;
                word_d[1] = in_b;
                word_d[2] = in_c;
                word_d[3] = in_d;
                mask_d    = in_mask;
                lane_d    = first_idx;
                last_d    = first_last;
                state_d   = SEND;
            end else begin
                drop_d  = 1'b1;
                state_d = IDLE;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            lane_q  <= '0;
            last_q  <= 1'b0;
            mask_q  <= '0;
            drop_q  <= 1'b0;
            cnt_q   <= '0;
            for (int i = 0; i < LANE_CNT; i++) begin
                word_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            lane_q  <= lane_d;
            last_q  <= last_d;
            mask_q  <= mask_d;
            drop_q  <= drop_d;
            cnt_q   <= cnt_d;
            word_q  <= word_d;
        end
    end

endmodule

// File: tb/tb_quad_lane_serializer.sv
// Bench for quad_lane_serializer: directed scenarios plus random traffic against a queue-based model.
module tb_quad_lane_serializer;

    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready, in_ready_s;
    logic [3:0] in_a, in_b, in_c, in_d;
    logic [3:0] in_mask;
    logic       out_valid, out_valid_s;
    logic       out_ready;
    logic [3:0] out_data, out_data_s;
    logic [1:0] out_lane, out_lane_s;
    logic       out_last, out_last_s;
    logic       drop_pulse, drop_pulse_s;
    logic [15:0] sent_count;
    logic [1:0]  sent_count_s;

    quad_lane_serializer #(.WIDTH(4), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_c(in_c), .in_d(in_d), .in_mask(in_mask),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_lane(out_lane), .out_last(out_last),
        .drop_pulse(drop_pulse), .sent_count(sent_count)
    );

    quad_lane_serializer #(.WIDTH(4), .CNT_W(2)) dut_sat (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready_s),
        .in_a(in_a), .in_b(in_b), .in_c(in_c), .in_d(in_d), .in_mask(in_mask),
        .out_valid(out_valid_s), .out_ready(out_ready), .out_data(out_data_s),
        .out_lane(out_lane_s), .out_last(out_last_s),
        .drop_pulse(drop_pulse_s), .sent_count(sent_count_s)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] data;
        logic [1:0] lane;
        logic       last;
    } exp_t;

    exp_t        q[$];
    int          cnt_exp;
    int          cnt_sat_exp;
    logic        drop_exp;
    int          n_assert;
    int          n_fail;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic model_ready();
        return (q.size() == 0) || (out_ready && q.size() == 1);
    endfunction

    task automatic push_bundle(input logic [3:0] a, b, c, d, input logic [3:0] m);
        logic [3:0] w [4];
        exp_t e;
        w[0] = a; w[1] = b; w[2] = c; w[3] = d;
        for (int i = 0; i < 4; i++) begin
            if (m[i]) begin
                e.data = w[i];
                e.lane = 2'(i);
                e.last = ((m >> (i + 1)) == 4'b0000);
                q.push_back(e);
            end
        end
    endtask

    task automatic check_outputs();
        chk("in_ready", 32'(in_ready), 32'(model_ready()));
        chk("out_valid", 32'(out_valid), 32'(q.size() != 0));
        if (q.size() != 0) begin
            chk("out_data", 32'(out_data), 32'(q[0].data));
            chk("out_lane", 32'(out_lane), 32'(q[0].lane));
            chk("out_last", 32'(out_last), 32'(q[0].last));
        end
        chk("drop_pulse", 32'(drop_pulse), 32'(drop_exp));
        chk("sent_count", 32'(sent_count), 32'(cnt_exp));
        chk("sent_count_sat", 32'(sent_count_s), 32'(cnt_sat_exp));
    endtask

    // One clock: check at negedge, advance the model at posedge, return 1 time unit later.
    task automatic step();
        logic hs, acc;
        @(negedge clk);
        check_outputs();
        hs  = (q.size() != 0) && out_ready;
        acc = in_valid && model_ready();
        @(posedge clk);
        if (hs) begin
            void'(q.pop_front());
            if (cnt_exp < 65535) cnt_exp++;
            if (cnt_sat_exp < 3) cnt_sat_exp++;
        end
        drop_exp = 1'b0;
        if (acc) begin
            if (in_mask == 4'b0000) drop_exp = 1'b1;
            else push_bundle(in_a, in_b, in_c, in_d, in_mask);
        end
        #1;
    endtask

    task automatic send_bundle(input logic [3:0] a, b, c, d, input logic [3:0] m);
        logic acc_now;
        logic accepted;
        accepted = 1'b0;
        in_a = a; in_b = b; in_c = c; in_d = d; in_mask = m;
        in_valid = 1'b1;
        for (int k = 0; k < 50; k++) begin
            acc_now = model_ready();
            step();
            if (acc_now) begin
                accepted = 1'b1;
                break;
            end
        end
        in_valid = 1'b0;
        if (!accepted) chk("accept_timeout", 32'(accepted), 32'd1);
    endtask

    task automatic drain();
        for (int k = 0; k < 40 && q.size() != 0; k++) step();
        step();
    endtask

    initial begin
        n_assert = 0; n_fail = 0;
        cnt_exp = 0; cnt_sat_exp = 0; drop_exp = 1'b0;
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        in_a = '0; in_b = '0; in_c = '0; in_d = '0; in_mask = '0;

        #3;
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_data", 32'(out_data), 32'd0);
        chk("rst_out_lane", 32'(out_lane), 32'd0);
        chk("rst_out_last", 32'(out_last), 32'd0);
        chk("rst_drop", 32'(drop_pulse), 32'd0);
        chk("rst_count", 32'(sent_count), 32'd0);
        #9 rst_n = 1'b1;
        @(posedge clk); #1;

        // Full mask
        send_bundle(4'd4, 4'd1, 4'd2, 4'd2, 4'b1111);
        drain();
        chk("full_count", 32'(sent_count), 32'd4);

        // Sparse mask
        send_bundle(4'd4, 4'd9, 4'd2, 4'd7, 4'b0101);
        drain();

        // Backpressure on lane 2
        send_bundle(4'd4, 4'd1, 4'd2, 4'd2, 4'b1111);
        step();
        step();
        out_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            in_valid = 1'b1;
            in_a = 4'($urandom); in_b = 4'($urandom); in_c = 4'($urandom); in_d = 4'($urandom);
            in_mask = 4'($urandom);
            #3;
            chk("stall_data", 32'(out_data), 32'd2);
            chk("stall_lane", 32'(out_lane), 32'd2);
            step();
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        drain();

        // All-masked bundle
        send_bundle(4'd5, 4'd5, 4'd5, 4'd5, 4'b0000);
        #3;
        chk("drop_high", 32'(drop_pulse), 32'd1);
        chk("drop_no_valid", 32'(out_valid), 32'd0);
        step();
        step();

        // Back-to-back: second bundle offered on the last handshake
        send_bundle(4'd3, 4'd6, 4'd8, 4'd10, 4'b1111);
        while (q.size() > 1) step();
        in_valid = 1'b1;
        in_a = 4'd0; in_b = 4'd0; in_c = 4'd0; in_d = 4'd1; in_mask = 4'b1000;
        #3;
        chk("b2b_in_ready", 32'(in_ready), 32'd1);
        step();
        in_valid = 1'b0;
        #3;
        chk("b2b_valid", 32'(out_valid), 32'd1);
        chk("b2b_data", 32'(out_data), 32'd1);
        chk("b2b_lane", 32'(out_lane), 32'd3);
        chk("b2b_last", 32'(out_last), 32'd1);
        drain();

        // Random traffic
        for (int k = 0; k < 400; k++) begin
            in_valid = 1'($urandom);
            in_a = 4'($urandom); in_b = 4'($urandom); in_c = 4'($urandom); in_d = 4'($urandom);
            in_mask = 4'($urandom);
            out_ready = ($urandom_range(0, 3) != 0);
            step();
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        drain();

        // Reset in the middle of a bundle
        out_ready = 1'b0;
        send_bundle(4'd7, 4'd7, 4'd7, 4'd7, 4'b1111);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_valid", 32'(out_valid), 32'd0);
        chk("midrst_count", 32'(sent_count), 32'd0);
        chk("midrst_in_ready", 32'(in_ready), 32'd1);
        q.delete();
        cnt_exp = 0; cnt_sat_exp = 0; drop_exp = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        #2 rst_n = 1'b1;
        @(posedge clk); #1;

        // Saturation: five transfers into a 2-bit counter
        send_bundle(4'd1, 4'd2, 4'd3, 4'd4, 4'b1111);
        drain();
        send_bundle(4'd5, 4'd6, 4'd7, 4'd8, 4'b0010);
        drain();
        chk("sat_count", 32'(sent_count_s), 32'd3);
        chk("wide_count", 32'(sent_count), 32'd5);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
